// File: rtl/hyperbus_mem_responder_if.sv
// HyperBus link signals between a controller-side PHY and the memory device.
//   hyper_cs_ni      chip select, active low       (controller -> device)
//   hyper_ck_i       bus clock                     (controller -> device)
//   hyper_dq_i       write/command data            (controller -> device)
//   hyper_rwds_i     write byte mask, 1 = masked   (controller -> device)
//   hyper_dq_o       read data                     (device -> controller)
//   hyper_dq_oe_o    DQ output enable              (device -> controller)
//   hyper_rwds_o     latency flag / read strobe    (device -> controller)
//   hyper_rwds_oe_o  RWDS output enable            (device -> controller)
interface hyperbus_mem_responder_if;
  logic       hyper_cs_ni;
  logic       hyper_ck_i;
  logic [7:0] hyper_dq_i;
  logic       hyper_rwds_i;
  logic [7:0] hyper_dq_o;
  logic       hyper_dq_oe_o;
  logic       hyper_rwds_o;
  logic       hyper_rwds_oe_o;

  modport master (
    output hyper_cs_ni, hyper_ck_i, hyper_dq_i, hyper_rwds_i,
    input  hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
  );

  modport slave (
    input  hyper_cs_ni, hyper_ck_i, hyper_dq_i, hyper_rwds_i,
    output hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
  );
endinterface

// File: rtl/hyperbus_mem_responder.sv
// HyperRAM-style memory responder: device end of a HyperBus link.
// Decodes the 48-bit command/address, flags latency on RWDS, serves linear
// read/write bursts from a 16-bit word array and holds configuration reg CR0.
// The bus clock is oversampled by clk_i; every level change of hyper_ck_i
// seen while selected is one bus edge carrying one byte.
// Ports:
//   clk_i      system clock (>= 2x bus clock)
//   rst_ni     asynchronous reset, active low
//   bus        HyperBus link, slave side
//   cfg_reg_o  current CR0 value
//   error_o    one-cycle pulse on first out-of-range word of a transaction
module hyperbus_mem_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 6,
  parameter logic [15:0] CFG_RESET   = 16'h8F1F
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  hyperbus_mem_responder_if.slave   bus,
  output logic [15:0]               cfg_reg_o,
  output logic                      error_o
);

  localparam int AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Edges to skip after CA; the 6 CA edges already cover part of the latency.
  localparam int LAT_1X = (WAIT_CYCLES > 2) ? 2 * WAIT_CYCLES - 4 : 0;
  localparam int LAT_2X = (WAIT_CYCLES > 1) ? 4 * WAIT_CYCLES - 4 : 0;

  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WR, S_RD, S_REGW} state_t;

  state_t      state, state_nx;
  logic        ck_q;
  logic        bus_edge;
  logic [39:0] ca;
  logic [47:0] ca_nx;
  logic        ca_last;
  logic [2:0]  ca_cnt;
  logic [15:0] lat_cnt;
  logic [15:0] lat_total;
  logic [15:0] lat_sel;
  logic        is_read;
  logic        is_reg;
  logic [31:0] addr;
  logic        lo_phase;   // 0: next edge carries the upper byte
  logic [7:0]  hi_byte;
  logic        hi_mask;
  logic        reg_done;
  logic        err_done;
  logic [7:0]  dq_q;
  logic        rwds_q;
  logic        in_range;
  logic [15:0] rd_word;
  logic        dq_oe;
  logic        rwds_oe;
  logic        rwds_out;
  logic        unused_ca;

  logic [15:0] mem [MEM_WORDS];

  // Edges are only meaningful while selected; this also drops a half word
  // or half CA when CS rises.
  assign bus_edge  = (bus.hyper_ck_i != ck_q) && !bus.hyper_cs_ni;
  assign ca_nx     = {ca, bus.hyper_dq_i};
  assign ca_last   = bus_edge && (ca_cnt == 3'd5);
  assign lat_sel   = cfg_reg_o[3] ? 16'(LAT_2X) : 16'(LAT_1X);
  assign in_range  = addr < 32'(MEM_WORDS);
  // Burst type and reserved CA bits carry no meaning here.
  assign unused_ca = ^{ca_nx[45], ca_nx[15:3]};

  always_comb begin
    rd_word = 16'h0000;
    if (is_reg) begin
      rd_word = cfg_reg_o;
    end else if (in_range) begin
      rd_word = mem[addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dq_oe    = 1'b0;
    rwds_oe  = 1'b0;
    rwds_out = rwds_q;
    unique case (state)
      S_IDLE: begin
        if (!bus.hyper_cs_ni) state_nx = S_CA;
      end
      S_CA: begin
        rwds_oe  = 1'b1;
        rwds_out = cfg_reg_o[3];
        if (ca_last) begin
          if (!ca_nx[47] && ca_nx[46]) begin
            state_nx = S_REGW;
          end else if (lat_sel == 16'd0) begin
            state_nx = ca_nx[47] ? S_RD : S_WR;
          end else begin
            state_nx = S_LAT;
          end
        end
      end
      S_LAT: begin
        if (bus_edge && (lat_cnt == lat_total - 16'd1)) begin
          state_nx = is_read ? S_RD : S_WR;
        end
      end
      S_RD: begin
        dq_oe   = 1'b1;
        rwds_oe = 1'b1;
      end
      default: ;
    endcase
    if (bus.hyper_cs_ni) state_nx = S_IDLE;
  end

  assign bus.hyper_dq_o      = dq_q;
  assign bus.hyper_dq_oe_o   = dq_oe;
  assign bus.hyper_rwds_o    = rwds_out;
  assign bus.hyper_rwds_oe_o = rwds_oe;

  // Control state, output registers and CR0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ck_q      <= 1'b0;
      ca_cnt    <= 3'd0;
      lat_cnt   <= 16'd0;
      lat_total <= 16'd0;
      lo_phase  <= 1'b0;
      reg_done  <= 1'b0;
      err_done  <= 1'b0;
      dq_q      <= 8'h00;
      rwds_q    <= 1'b0;
      error_o   <= 1'b0;
      cfg_reg_o <= CFG_RESET;
    end else begin
      ck_q    <= bus.hyper_ck_i;
      error_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          ca_cnt   <= 3'd0;
          lat_cnt  <= 16'd0;
          lo_phase <= 1'b0;
          reg_done <= 1'b0;
          err_done <= 1'b0;
        end
        S_CA: begin
          if (bus_edge) ca_cnt <= ca_cnt + 3'd1;
          if (ca_last) begin
            lat_total <= lat_sel;
            lat_cnt   <= 16'd0;
            lo_phase  <= 1'b0;
          end
        end
        S_LAT: begin
          if (bus_edge) lat_cnt <= lat_cnt + 16'd1;
        end
        S_WR: begin
          if (bus_edge) begin
            lo_phase <= ~lo_phase;
            if (lo_phase && !in_range && !err_done) begin
              error_o  <= 1'b1;
              err_done <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (bus_edge) begin
            lo_phase <= ~lo_phase;
            if (!lo_phase) begin
              dq_q   <= rd_word[15:8];
              rwds_q <= 1'b1;
              if (!is_reg && !in_range && !err_done) begin
                error_o  <= 1'b1;
                err_done <= 1'b1;
              end
            end else begin
              dq_q   <= rd_word[7:0];
              rwds_q <= 1'b0;
            end
          end
        end
        S_REGW: begin
          if (bus_edge && !reg_done) begin
            lo_phase <= ~lo_phase;
            if (lo_phase) begin
              cfg_reg_o <= {hi_byte, bus.hyper_dq_i};
              reg_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: CA shift register, burst address, byte staging and the array.
  always_ff @(posedge clk_i) begin
    if (bus_edge) begin
      unique case (state)
        S_CA: begin
          ca <= ca_nx[39:0];
          if (ca_cnt == 3'd5) begin
            addr    <= {ca_nx[44:16], ca_nx[2:0]};
            is_read <= ca_nx[47];
            is_reg  <= ca_nx[46];
          end
        end
        S_WR: begin
          if (!lo_phase) begin
            hi_byte <= bus.hyper_dq_i;
            hi_mask <= bus.hyper_rwds_i;
          end else begin
            if (in_range) begin
              if (!hi_mask)          mem[addr[AW-1:0]][15:8] <= hi_byte;
              if (!bus.hyper_rwds_i) mem[addr[AW-1:0]][7:0]  <= bus.hyper_dq_i;
            end
            addr <= addr + 32'd1;
          end
        end
        S_RD: begin
          if (lo_phase) addr <= addr + 32'd1;
        end
        S_REGW: begin
          if (!lo_phase) hi_byte <= bus.hyper_dq_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
module tb_hyperbus_mem_responder;
  localparam int          MEM_WORDS   = 1024;
  localparam int          WAIT_CYCLES = 6;
  localparam logic [15:0] CFG_RESET   = 16'h8F1F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_reg;
  logic        error;

  hyperbus_mem_responder_if bus ();

  hyperbus_mem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .WAIT_CYCLES(WAIT_CYCLES),
    .CFG_RESET  (CFG_RESET)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .bus      (bus),
    .cfg_reg_o(cfg_reg),
    .error_o  (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  // Reference model: word array with validity, and CR0.
  logic [15:0] mem_model [MEM_WORDS];
  bit          mem_valid [MEM_WORDS];
  logic [15:0] cfg_model;
  logic [15:0] wbuf [16];
  logic [1:0]  mbuf [16];

  always @(negedge clk) if (error === 1'b1) err_pulses++;

  function automatic int lat_edges(input logic [15:0] cfg);
    return 2 * WAIT_CYCLES * (cfg[3] ? 2 : 1) - 4;
  endfunction

  function automatic logic [47:0] make_ca(input bit rd, input bit rg, input logic [31:0] a);
    logic burst;
    burst = 1'($urandom_range(0, 1));
    return {rd, rg, burst, a[31:3], 13'h0000, a[2:0]};
  endfunction

  // One bus edge, optionally after a pause with CK held.
  task automatic edge_drive(input logic [7:0] d, input logic m);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(negedge clk);
    bus.hyper_dq_i   = d;
    bus.hyper_rwds_i = m;
    bus.hyper_ck_i   = ~bus.hyper_ck_i;
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [47:0] ca, input string name);
    @(negedge clk);
    bus.hyper_cs_ni = 1'b0;
    for (int i = 0; i < 6; i++) begin
      edge_drive(ca[47-8*i -: 8], 1'b0);
      if (i < 5) begin
        checks++;
        if ({bus.hyper_rwds_oe_o, bus.hyper_rwds_o} !== {1'b1, cfg_model[3]}) begin
          failures++;
          $display("FAIL %s_ca_rwds byte %0d: rwds_oe=%b rwds=%b, expected rwds_oe=1 rwds=%b",
                   name, i, bus.hyper_rwds_oe_o, bus.hyper_rwds_o, cfg_model[3]);
        end
      end
    end
  endtask

  task automatic end_txn(input string name);
    @(negedge clk);
    bus.hyper_cs_ni = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o} !== 2'b00) begin
      failures++;
      $display("FAIL %s_end_oe: dq_oe=%b rwds_oe=%b, expected 0 0",
               name, bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o);
    end
  endtask

  task automatic do_latency(input bit is_read, input string name);
    int n;
    n = lat_edges(cfg_model);
    for (int i = 0; i < n; i++) begin
      edge_drive(8'($urandom), 1'b0);
      if (is_read) begin
        checks++;
        if (bus.hyper_dq_oe_o !== ((i == n - 1) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL %s_latency edge %0d of %0d: dq_oe=%b, expected %b",
                   name, i + 1, n, bus.hyper_dq_oe_o, (i == n - 1));
        end
      end
    end
  endtask

  task automatic write_txn(input logic [31:0] a, input int n, input string name);
    int unsigned idx;
    bit oor;
    int e0;
    oor = 1'b0;
    e0  = err_pulses;
    start_txn(make_ca(1'b0, 1'b0, a), name);
    do_latency(1'b0, name);
    for (int w = 0; w < n; w++) begin
      idx = a + 32'(w);
      edge_drive(wbuf[w][15:8], mbuf[w][1]);
      edge_drive(wbuf[w][7:0], mbuf[w][0]);
      if (idx < MEM_WORDS) begin
        if (!mbuf[w][1]) mem_model[idx][15:8] = wbuf[w][15:8];
        if (!mbuf[w][0]) mem_model[idx][7:0]  = wbuf[w][7:0];
        if (mbuf[w] == 2'b00) mem_valid[idx] = 1'b1;
      end else begin
        oor = 1'b1;
      end
    end
    end_txn(name);
    checks++;
    if ((err_pulses - e0) != (oor ? 1 : 0)) begin
      failures++;
      $display("FAIL %s_wr_error: pulses=%0d, expected %0d", name, err_pulses - e0, oor ? 1 : 0);
    end
  endtask

  task automatic read_txn(input logic [31:0] a, input int n, input bit is_reg, input string name);
    int unsigned idx;
    logic [15:0] exp;
    bit known;
    bit oor;
    int e0;
    oor = 1'b0;
    e0  = err_pulses;
    start_txn(make_ca(1'b1, is_reg, a), name);
    do_latency(1'b1, name);
    for (int w = 0; w < n; w++) begin
      idx   = a + 32'(w);
      known = 1'b1;
      if (is_reg) begin
        exp = cfg_model;
      end else if (idx >= MEM_WORDS) begin
        exp = 16'h0000;
        oor = 1'b1;
      end else begin
        exp   = mem_model[idx];
        known = mem_valid[idx];
      end
      edge_drive(8'($urandom), 1'b0);
      if (known) begin
        checks++;
        if ({bus.hyper_dq_o, bus.hyper_rwds_o, bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o} !==
            {exp[15:8], 3'b111}) begin
          failures++;
          $display("FAIL %s_rd_hi word %0d: dq=%h rwds=%b dq_oe=%b rwds_oe=%b, expected dq=%h rwds=1 oe=1",
                   name, w, bus.hyper_dq_o, bus.hyper_rwds_o, bus.hyper_dq_oe_o,
                   bus.hyper_rwds_oe_o, exp[15:8]);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.hyper_dq_o, bus.hyper_rwds_o} !== {exp[15:8], 1'b1}) begin
          failures++;
          $display("FAIL %s_rd_hold word %0d: dq=%h rwds=%b, expected dq=%h rwds=1",
                   name, w, bus.hyper_dq_o, bus.hyper_rwds_o, exp[15:8]);
        end
      end
      edge_drive(8'($urandom), 1'b0);
      if (known) begin
        checks++;
        if ({bus.hyper_dq_o, bus.hyper_rwds_o} !== {exp[7:0], 1'b0}) begin
          failures++;
          $display("FAIL %s_rd_lo word %0d: dq=%h rwds=%b, expected dq=%h rwds=0",
                   name, w, bus.hyper_dq_o, bus.hyper_rwds_o, exp[7:0]);
        end
      end
    end
    end_txn(name);
    checks++;
    if ((err_pulses - e0) != (oor ? 1 : 0)) begin
      failures++;
      $display("FAIL %s_rd_error: pulses=%0d, expected %0d", name, err_pulses - e0, oor ? 1 : 0);
    end
  endtask

  task automatic reg_write(input logic [47:0] ca, input logic [15:0] v, input string name);
    start_txn(ca, name);
    edge_drive(v[15:8], 1'b1);
    checks++;
    if ({bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o} !== 2'b00) begin
      failures++;
      $display("FAIL %s_regw_oe: dq_oe=%b rwds_oe=%b, expected 0 0",
               name, bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o);
    end
    edge_drive(v[7:0], 1'b1);
    // Further edges in the same transaction must not touch CR0.
    edge_drive(~v[15:8], 1'b0);
    edge_drive(~v[7:0], 1'b0);
    checks++;
    if ({bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o} !== 2'b00) begin
      failures++;
      $display("FAIL %s_regw_oe2: dq_oe=%b rwds_oe=%b, expected 0 0",
               name, bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o);
    end
    end_txn(name);
    cfg_model = v;
    checks++;
    if (cfg_reg !== cfg_model) begin
      failures++;
      $display("FAIL %s_cfg: cfg=%h, expected %h", name, cfg_reg, cfg_model);
    end
  endtask

  task automatic test_reset;
    bus.hyper_cs_ni  = 1'b1;
    bus.hyper_ck_i   = 1'b0;
    bus.hyper_dq_i   = 8'h00;
    bus.hyper_rwds_i = 1'b0;
    cfg_model        = CFG_RESET;
    rst_n            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.hyper_dq_o, bus.hyper_dq_oe_o, bus.hyper_rwds_o, bus.hyper_rwds_oe_o, error, cfg_reg} !==
        {8'h00, 4'b0000, CFG_RESET}) begin
      failures++;
      $display("FAIL reset_values: dq=%h dq_oe=%b rwds=%b rwds_oe=%b err=%b cfg=%h, expected zeros cfg=%h",
               bus.hyper_dq_o, bus.hyper_dq_oe_o, bus.hyper_rwds_o, bus.hyper_rwds_oe_o,
               error, cfg_reg, CFG_RESET);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o, cfg_reg} !== {2'b00, CFG_RESET}) begin
      failures++;
      $display("FAIL reset_idle: dq_oe=%b rwds_oe=%b cfg=%h, expected 0 0 %h",
               bus.hyper_dq_oe_o, bus.hyper_rwds_oe_o, cfg_reg, CFG_RESET);
    end
  endtask

  task automatic test_write_read;
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 16'h1111 * 16'(i + 1);
      mbuf[i] = 2'b00;
    end
    write_txn(32'h10, 4, "wr4");
    read_txn(32'h10, 4, 1'b0, "rd4");
  endtask

  task automatic test_byte_mask;
    wbuf[0] = 16'h1234;
    mbuf[0] = 2'b00;
    write_txn(32'h40, 1, "mask_init");
    wbuf[0] = 16'hABCD;
    mbuf[0] = 2'b01;
    write_txn(32'h40, 1, "mask_wr");
    read_txn(32'h40, 1, 1'b0, "mask_rd");
  endtask

  task automatic test_abort;
    wbuf[0] = 16'hAAAA;
    wbuf[1] = 16'hBBBB;
    mbuf[0] = 2'b00;
    mbuf[1] = 2'b00;
    write_txn(32'h20, 2, "abort_init");
    start_txn(make_ca(1'b0, 1'b0, 32'h20), "abort");
    do_latency(1'b0, "abort");
    edge_drive(8'h5A, 1'b0);
    edge_drive(8'h5B, 1'b0);
    edge_drive(8'hC3, 1'b0);
    mem_model[32'h20] = 16'h5A5B;
    end_txn("abort");
    read_txn(32'h20, 2, 1'b0, "abort_rd");
  endtask

  task automatic test_reg_access;
    reg_write(48'h6000_0000_0000, 16'h8F17, "regw");
    read_txn(32'($urandom), 2, 1'b1, "regrd");
  endtask

  task automatic test_out_of_range;
    read_txn(32'(MEM_WORDS), 2, 1'b0, "oor_rd");
    wbuf[0] = 16'h0F0F;
    mbuf[0] = 2'b00;
    write_txn(32'h0, 1, "oor_init");
    wbuf[0] = 16'hDEAD;
    write_txn(32'(MEM_WORDS), 1, "oor_wr");
    read_txn(32'h0, 1, 1'b0, "oor_alias");
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 16'($urandom);
      mbuf[i] = 2'b00;
    end
    write_txn(32'(MEM_WORDS - 2), 4, "oor_wr_cross");
    read_txn(32'(MEM_WORDS - 2), 4, 1'b0, "oor_rd_cross");
  endtask

  task automatic test_random;
    logic [31:0] a;
    int n;
    for (int it = 0; it < 6; it++) begin
      reg_write(make_ca(1'b0, 1'b1, 32'($urandom)), 16'($urandom), "rnd_cfg");
      a = 32'($urandom_range(0, MEM_WORDS - 8));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 16'($urandom);
        mbuf[i] = 2'b00;
      end
      write_txn(a, n, "rnd_wr");
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 16'($urandom);
        mbuf[i] = 2'($urandom);
      end
      write_txn(a, n, "rnd_wrm");
      read_txn(a, n, 1'b0, "rnd_rd");
    end
  endtask

  task automatic test_reset_mid_read;
    reg_write(48'h6000_0000_0000, 16'h0007, "rst_cfg");
    start_txn(make_ca(1'b1, 1'b0, 32'h10), "rst_mid");
    do_latency(1'b1, "rst_mid");
    edge_drive(8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.hyper_dq_o, bus.hyper_dq_oe_o, bus.hyper_rwds_o, bus.hyper_rwds_oe_o, error, cfg_reg} !==
        {8'h00, 4'b0000, CFG_RESET}) begin
      failures++;
      $display("FAIL reset_mid_read: dq=%h dq_oe=%b rwds=%b rwds_oe=%b err=%b cfg=%h, expected zeros cfg=%h",
               bus.hyper_dq_o, bus.hyper_dq_oe_o, bus.hyper_rwds_o, bus.hyper_rwds_oe_o,
               error, cfg_reg, CFG_RESET);
    end
    cfg_model = CFG_RESET;
    bus.hyper_cs_ni = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    read_txn(32'h10, 4, 1'b0, "post_rst_rd");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_abort();
    test_reg_access();
    test_out_of_range();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hyperbus_mem_responder.md
# hyperbus_mem_responder

Synthesizable HyperRAM-style memory responder: the device end of the HyperBus link that the controller-side PHY drives. It decodes the 48-bit command/address, signals latency on RWDS, serves linear read and write bursts from an internal 16-bit word array, and holds configuration register CR0. It sits in simulation and FPGA test harnesses as the target for the HyperBus PHY. All logic runs on one system clock, which oversamples the bus clock.

## Interface
- MEM_WORDS, 1024: depth of the internal array in 16-bit words.
- WAIT_CYCLES, 6: initial latency in CK cycles, before any doubling.
- CFG_RESET, 16'h8F1F: reset value of CR0. Bit 3 set means fixed 2x latency.
- clk_i  in  1  system clock. Must run at least 2x the CK frequency.
- rst_ni  in  1  asynchronous reset, active low.
- hyper_cs_ni  in  1  chip select, active low.
- hyper_ck_i  in  1  bus clock, sampled as data.
- hyper_dq_i  in  8  bus data from the controller.
- hyper_dq_o  out  8  read data.
- hyper_dq_oe_o  out  1  DQ output enable.
- hyper_rwds_i  in  1  write byte mask (1 = byte masked).
- hyper_rwds_o  out  1  latency indication during CA; read strobe during read data.
- hyper_rwds_oe_o  out  1  RWDS output enable.
- cfg_reg_o  out  16  current CR0 value.
- error_o  out  1  one-cycle pulse on the first out-of-range word access in a transaction.

## Operation
- Bus-edge detection:
  - ck_q registers hyper_ck_i.
  - A bus edge occurs in a clk_i cycle where hyper_ck_i != ck_q. At most one edge per clk_i cycle.
  - hyper_dq_i and hyper_rwds_i are captured in the same cycle as the edge.
- State machine: IDLE, CA, LAT, WR, RD, REGW.
  - IDLE -> CA when hyper_cs_ni is low.
  - CA: shift in 6 bytes, MSB first, into ca[47:0].
  - After the 6th byte:
    - ca[47]=0 and ca[46]=1: go to REGW (no latency).
    - Otherwise: go to LAT.
- Command fields:
  - ca[47] = read.
  - ca[46] = register space.
  - ca[45] (burst type) is ignored; all bursts are linear.
  - Word address = {ca[44:16], ca[2:0]}.
- Latency indication:
  - In CA: hyper_rwds_oe_o=1 and hyper_rwds_o=cfg_reg_o[3].
  - mult = cfg_reg_o[3] ? 2 : 1.
- LAT: skip 2*WAIT_CYCLES*mult - 4 edges, then go to RD (read) or WR (write).
- WR: edges alternate between upper byte and lower byte.
  - Upper byte is taken when hyper_rwds_i=0 on its edge; lower byte likewise.
  - A word is committed on the lower-byte edge, with masked bytes left unchanged.
  - The address increments by 1 after each word.
- RD: edges alternate upper/lower byte of mem[addr]; the address increments after each lower byte.
  - hyper_dq_oe_o=1 and hyper_rwds_oe_o=1.
  - hyper_rwds_o=1 with the upper byte and 0 with the lower byte.
- Register space:
  - REGW: 2 edges form a word, written to CR0 without masking, then stay in REGW and ignore further edges.
  - Register read (ca[47]=1, ca[46]=1): follows LAT/RD and returns cfg_reg_o for every word.
- Out of range (addr >= MEM_WORDS):
  - Reads return 16'h0000.
  - Writes are dropped.
  - error_o pulses once per transaction.
- Address arithmetic is 32-bit modulo; no wrap at MEM_WORDS.

## Timing
- Reset values:
  - hyper_dq_o=0, hyper_dq_oe_o=0, hyper_rwds_o=0, hyper_rwds_oe_o=0, error_o=0.
  - cfg_reg_o=CFG_RESET. State=IDLE.
  - Array contents are not reset.
- Read output latency:
  - The byte for the edge detected in cycle t is on hyper_dq_o/hyper_rwds_o from cycle t+1.
  - It is held until the next edge's update.
- Output enables:
  - hyper_dq_oe_o rises in the cycle after the last LAT edge.
  - hyper_rwds_oe_o is high throughout CA and RD.
- Memory write: the word is visible in the array the cycle after the lower-byte edge.
- CS high in any state:
  - Next cycle: state=IDLE and all oe=0.
  - A half-received word (upper byte only) is discarded.
  - A half-received CA is discarded.
- CK stopped mid-burst: no edges, so state and address hold; the burst resumes on the next edge.
- Reset mid-transaction: immediate return to reset values; CR0 reverts to CFG_RESET.

## Test plan
- Reset: assert rst_ni low mid-read -> all oe=0, cfg_reg_o=16'h8F1F in the same cycle.
- Register write: CA 0x600000000000 followed by bytes 0x8F, 0x17 -> cfg_reg_o=16'h8F17, and no DQ/RWDS drive.
- Write then read, CR0 default (fixed 2x latency):
  - Write 4 words 0x1111..0x4444 at address 0x10, then read 4 words.
  - Required: rwds_o=1 during CA, 20 latency edges, readback 0x1111,0x2222,0x3333,0x4444 with RWDS toggling 1,0 per word.
- Byte mask: write 0xABCD to a word holding 0x1234 with rwds_i high on the lower-byte edge -> readback 0xAB34.
- Abort:
  - Raise CS after 3 write bytes -> only the first word is committed; next cycle oe=0, state IDLE.
  - A following read still decodes correctly.
- Out-of-range and variable latency:
  - Clear CR0[3], then read address MEM_WORDS.
  - Required: rwds_o=0 during CA, 8 latency edges, data 0x0000, a single error_o pulse.
